// File: rtl/sha256_block_sequencer.sv
// sha256_block_sequencer: message padding front end for the SHA-256 core.
// Packs 32-bit big-endian words into 512-bit blocks with first/final flags.
module sha256_block_sequencer #(
    parameter int LEN_W = 61
) (
    input  logic         sha256seq_clock_i,
    input  logic         sha256seq_reset_ni,
    input  logic [31:0]  word_i,
    input  logic [2:0]   bytes_i,
    input  logic         last_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic [511:0] block_o,
    output logic         first_o,
    output logic         final_o,
    output logic         blk_valid_o,
    input  logic         blk_accept_i,
    output logic         busy_o
);
    typedef enum logic [1:0] {S_FILL, S_PAD, S_LEN, S_ISSUE} state_t;

    state_t           r_state, w_state_n;
    state_t           r_ret, w_ret_n;
    logic [31:0]      r_buf [16];
    logic [3:0]       r_widx, w_widx_n;
    logic [LEN_W-1:0] r_count, w_count_n;
    logic             r_first, w_first_n;
    logic             r_pend, w_pend_n;
    logic             r_fin, w_fin_n;
    logic             r_busy, w_busy_n;
    logic             r_ready, r_blk_valid, r_first_o, r_final_o;
    logic             w_acc, w_take, w_we, w_len, w_clr;
    logic [31:0]      w_wd, w_mask, w_mark;
    logic [2:0]       w_nb;
    logic [63:0]      w_bits;

    assign w_acc  = valid_i & r_ready;
    assign w_take = r_blk_valid & blk_accept_i;
    assign w_nb   = (bytes_i > 3'd4) ? 3'd4 : bytes_i;
    assign w_bits = 64'({r_count, 3'b000});

    // Keep the valid leading bytes; the marker lands right after them.
    always_comb begin
        w_mask = 32'hFFFF_FFFF;
        w_mark = 32'h0;
        unique case (w_nb)
            3'd0:    begin w_mask = 32'h0000_0000; w_mark = 32'h8000_0000; end
            3'd1:    begin w_mask = 32'hFF00_0000; w_mark = 32'h0080_0000; end
            3'd2:    begin w_mask = 32'hFFFF_0000; w_mark = 32'h0000_8000; end
            3'd3:    begin w_mask = 32'hFFFF_FF00; w_mark = 32'h0000_0080; end
            default: begin w_mask = 32'hFFFF_FFFF; w_mark = 32'h0; end
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        w_ret_n   = r_ret;
        w_widx_n  = r_widx;
        w_count_n = r_count;
        w_first_n = r_first;
        w_pend_n  = r_pend;
        w_fin_n   = r_fin;
        w_busy_n  = r_busy;
        w_we      = 1'b0;
        w_len     = 1'b0;
        w_clr     = 1'b0;
        w_wd      = 32'h0;
        unique case (r_state)
            S_FILL: begin
                if (w_acc) begin
                    w_we      = 1'b1;
                    w_wd      = (word_i & w_mask) | (last_i ? w_mark : 32'h0);
                    w_widx_n  = r_widx + 4'd1;
                    w_count_n = r_count + LEN_W'(w_nb);
                    w_busy_n  = 1'b1;
                    w_fin_n   = 1'b0;
                    w_pend_n  = last_i && (w_nb == 3'd4);
                    if (r_widx == 4'd15) begin
                        w_state_n = S_ISSUE;
                        w_ret_n   = last_i ? S_PAD : S_FILL;
                    end else if (last_i) begin
                        w_state_n = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (r_widx == 4'd14 && !r_pend) begin
                    w_state_n = S_LEN;
                end else begin
                    w_we     = 1'b1;
                    w_wd     = r_pend ? 32'h8000_0000 : 32'h0;
                    w_pend_n = 1'b0;
                    w_widx_n = r_widx + 4'd1;
                    if (r_widx == 4'd15) begin
                        w_state_n = S_ISSUE;
                        w_ret_n   = S_PAD;
                    end
                end
            end
            S_LEN: begin
                w_len     = 1'b1;
                w_fin_n   = 1'b1;
                w_state_n = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_take) begin
                    w_clr     = 1'b1;
                    w_widx_n  = 4'd0;
                    w_first_n = 1'b0;
                    if (r_fin) begin
                        w_state_n = S_FILL;
                        w_count_n = '0;
                        w_first_n = 1'b1;
                        w_busy_n  = 1'b0;
                    end else begin
                        w_state_n = r_ret;
                    end
                end
            end
            default: w_state_n = S_FILL;
        endcase
    end

    always_ff @(posedge sha256seq_clock_i or negedge sha256seq_reset_ni) begin
        if (!sha256seq_reset_ni) begin
            r_state     <= S_FILL;
            r_ret       <= S_FILL;
            r_widx      <= 4'd0;
            r_count     <= '0;
            r_first     <= 1'b1;
            r_pend      <= 1'b0;
            r_fin       <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_blk_valid <= 1'b0;
            r_first_o   <= 1'b0;
            r_final_o   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ret       <= w_ret_n;
            r_widx      <= w_widx_n;
            r_count     <= w_count_n;
            r_first     <= w_first_n;
            r_pend      <= w_pend_n;
            r_fin       <= w_fin_n;
            r_busy      <= w_busy_n;
            // One idle FILL cycle after an issue before words are taken again.
            r_ready     <= (r_state == S_FILL) && (w_state_n == S_FILL);
            r_blk_valid <= (w_state_n == S_ISSUE);
            r_first_o   <= (w_state_n == S_ISSUE) && w_first_n;
            r_final_o   <= (w_state_n == S_ISSUE) && w_fin_n;
        end
    end

    always_ff @(posedge sha256seq_clock_i or negedge sha256seq_reset_ni) begin
        if (!sha256seq_reset_ni) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= 32'h0;
        end else if (w_clr) begin
            for (int i = 0; i < 16; i++) r_buf[i] <= 32'h0;
        end else if (w_len) begin
            r_buf[14] <= w_bits[63:32];
            r_buf[15] <= w_bits[31:0];
        end else if (w_we) begin
            r_buf[r_widx] <= w_wd;
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_blk
        assign block_o[32*k +: 32] = r_buf[k];
    end

    assign ready_o     = r_ready;
    assign blk_valid_o = r_blk_valid;
    assign first_o     = r_first_o;
    assign final_o     = r_final_o;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_sha256_block_sequencer.sv
// tb_sha256_block_sequencer: directed and randomized message padding tests
// against a byte-level padding model.
module tb_sha256_block_sequencer;
    typedef logic [511:0] blk_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  word_i;
    logic [2:0]   bytes_i;
    logic         last_i, valid_i, ready_o;
    logic [511:0] block_o;
    logic         first_o, final_o, blk_valid_o, blk_accept_i, busy_o;

    int checks = 0;
    int errors = 0;

    blk_t exp_blk[$];
    blk_t got_blk[$];
    bit   got_first[$];
    bit   got_final[$];
    bit   tmo;
    time  t_acc, t_val;

    always #5 clk = ~clk;

    sha256_block_sequencer #(.LEN_W(61)) dut (
        .sha256seq_clock_i (clk),
        .sha256seq_reset_ni(rst_n),
        .word_i            (word_i),
        .bytes_i           (bytes_i),
        .last_i            (last_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .block_o           (block_o),
        .first_o           (first_o),
        .final_o           (final_o),
        .blk_valid_o       (blk_valid_o),
        .blk_accept_i      (blk_accept_i),
        .busy_o            (busy_o)
    );

    // Padding model: append 0x80, zero to 56 mod 64, 64-bit bit length.
    function automatic void build_ref(input byte unsigned msg[$]);
        byte unsigned    p[$];
        longint unsigned bits;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = longint'(msg.size()) * 8;
        for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
        exp_blk.delete();
        for (int b = 0; b < p.size() / 64; b++) begin
            blk_t x;
            x = '0;
            for (int k = 0; k < 16; k++)
                x[32*k +: 32] = {p[64*b+4*k], p[64*b+4*k+1],
                                 p[64*b+4*k+2], p[64*b+4*k+3]};
            exp_blk.push_back(x);
        end
    endfunction

    function automatic blk_t wd(input int k, input logic [31:0] v);
        blk_t x;
        x = '0;
        x[32*k +: 32] = v;
        return x;
    endfunction

    function automatic logic [31:0] wo(input byte unsigned m[$], input int k);
        logic [31:0] v;
        v = 32'h0;
        for (int j = 0; j < 4; j++)
            if (4 * k + j < m.size()) v[31-8*j -: 8] = m[4*k+j];
        return v;
    endfunction

    function automatic void seq_msg(output byte unsigned m[$], input int n);
        m.delete();
        for (int i = 0; i < n; i++) m.push_back(8'(i + 1));
    endfunction

    // Streams the message in and collects issued blocks until the final one.
    task automatic run_msg(input byte unsigned msg[$], input bit empty_tail,
                           input int acc_pct);
        got_blk.delete(); got_first.delete(); got_final.delete();
        tmo = 0; t_acc = 0; t_val = 0;
        fork
            begin : drv
                int i;
                bit done;
                i = 0;
                done = 0;
                while (!done) begin
                    logic [31:0] w;
                    logic [2:0]  b;
                    bit          l, got;
                    int          rem, wt;
                    rem = msg.size() - i;
                    w = $urandom();
                    if (rem > 4 || (rem == 4 && empty_tail)) begin
                        b = 3'd4; l = 0;
                    end else begin
                        b = 3'(rem); l = 1;
                    end
                    for (int j = 0; j < int'(b); j++) w[31-8*j -: 8] = msg[i+j];
                    if ($urandom_range(0, 9) < 2) begin
                        valid_i = 0;
                        @(negedge clk);
                    end
                    word_i = w; bytes_i = b; last_i = l; valid_i = 1;
                    wt = 0;
                    forever begin
                        got = ready_o;
                        @(negedge clk);
                        if (got) break;
                        if (++wt > 2000) begin tmo = 1; break; end
                    end
                    i += int'(b);
                    if (l || tmo) done = 1;
                    if (l) t_acc = $time;
                end
                valid_i = 0; last_i = 0;
            end
            begin : col
                bit   pv, pf, pl, fin;
                blk_t pb;
                int   c;
                pv = 0; pf = 0; pl = 0; fin = 0; pb = '0; c = 0;
                blk_accept_i = 0;
                while (!fin) begin
                    @(negedge clk);
                    if (pv && blk_accept_i) begin
                        got_blk.push_back(pb);
                        got_first.push_back(pf);
                        got_final.push_back(pl);
                        if (pl) fin = 1;
                    end
                    pv = blk_valid_o; pb = block_o; pf = first_o; pl = final_o;
                    if (blk_valid_o && t_val == 0) t_val = $time;
                    blk_accept_i = (!fin && blk_valid_o) ?
                                   ($urandom_range(0, 99) < acc_pct) : 1'b0;
                    if (++c > 3000) begin tmo = 1; fin = 1; end
                end
                blk_accept_i = 0;
            end
        join
    endtask

    task automatic test_reset();
        rst_n = 0; valid_i = 0; word_i = 0; bytes_i = 0; last_i = 0;
        blk_accept_i = 0;
        #12;
        checks++;
        if ({ready_o, blk_valid_o, first_o, final_o, busy_o} !== 5'b0 ||
            block_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b f=%b l=%b busy=%b blk0=%b want all 0",
                     ready_o, blk_valid_o, first_o, final_o, busy_o, block_o == '0);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b want 1 0", ready_o, busy_o);
        end
    endtask

    task automatic test_abc();
        byte unsigned m[$];
        blk_t e;
        m = '{8'h61, 8'h62, 8'h63};
        e = wd(0, 32'h6162_6380) | wd(15, 32'h0000_0018);
        run_msg(m, 0, 100);
        checks++;
        if (tmo || got_blk.size() != 1) begin
            errors++;
            $display("FAIL abc_count: got %0d blocks tmo=%b want 1", got_blk.size(), tmo);
            return;
        end
        checks++;
        if (got_blk[0] !== e || got_first[0] !== 1 || got_final[0] !== 1) begin
            errors++;
            $display("FAIL abc_block: got %h f=%b l=%b want %h 1 1",
                     got_blk[0], got_first[0], got_final[0], e);
        end
        checks++;
        if ((t_val - t_acc) / 10 + 1 != 16) begin
            errors++;
            $display("FAIL abc_latency: got %0d want 16", (t_val - t_acc) / 10 + 1);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL abc_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_empty();
        byte unsigned m[$];
        blk_t e;
        m.delete();
        e = wd(0, 32'h8000_0000);
        run_msg(m, 0, 70);
        checks++;
        if (tmo || got_blk.size() != 1 || got_blk[0] !== e ||
            got_first[0] !== 1 || got_final[0] !== 1) begin
            errors++;
            $display("FAIL empty_block: got n=%0d %h want 1 %h", got_blk.size(),
                     got_blk.size() ? got_blk[0] : '0, e);
        end
    endtask

    task automatic test_55();
        byte unsigned m[$];
        blk_t e;
        seq_msg(m, 55);
        e = wd(13, wo(m, 13) | 32'h80) | wd(15, 32'h0000_01B8);
        for (int k = 0; k < 13; k++) e |= wd(k, wo(m, k));
        run_msg(m, 0, 100);
        checks++;
        if (tmo || got_blk.size() != 1 || got_blk[0] !== e || got_final[0] !== 1) begin
            errors++;
            $display("FAIL len55_block: got n=%0d %h want 1 %h", got_blk.size(),
                     got_blk.size() ? got_blk[0] : '0, e);
        end
    endtask

    task automatic test_56();
        byte unsigned m[$];
        blk_t e0, e1;
        seq_msg(m, 56);
        e0 = wd(14, 32'h8000_0000);
        for (int k = 0; k < 14; k++) e0 |= wd(k, wo(m, k));
        e1 = wd(15, 32'h0000_01C0);
        run_msg(m, 0, 60);
        checks++;
        if (tmo || got_blk.size() != 2) begin
            errors++;
            $display("FAIL len56_count: got %0d tmo=%b want 2", got_blk.size(), tmo);
            return;
        end
        checks++;
        if (got_blk[0] !== e0 || got_first[0] !== 1 || got_final[0] !== 0) begin
            errors++;
            $display("FAIL len56_blk1: got %h f=%b l=%b want %h 1 0",
                     got_blk[0], got_first[0], got_final[0], e0);
        end
        checks++;
        if (got_blk[1] !== e1 || got_first[1] !== 0 || got_final[1] !== 1) begin
            errors++;
            $display("FAIL len56_blk2: got %h f=%b l=%b want %h 0 1",
                     got_blk[1], got_first[1], got_final[1], e1);
        end
    endtask

    task automatic test_64();
        byte unsigned m[$];
        blk_t e0, e1;
        seq_msg(m, 64);
        e0 = '0;
        for (int k = 0; k < 16; k++) e0 |= wd(k, wo(m, k));
        e1 = wd(0, 32'h8000_0000) | wd(15, 32'h0000_0200);
        run_msg(m, 0, 100);
        checks++;
        if (tmo || got_blk.size() != 2) begin
            errors++;
            $display("FAIL len64_count: got %0d tmo=%b want 2", got_blk.size(), tmo);
            return;
        end
        checks++;
        if (got_blk[0] !== e0 || got_first[0] !== 1 || got_final[0] !== 0) begin
            errors++;
            $display("FAIL len64_blk1: got %h f=%b l=%b want %h 1 0",
                     got_blk[0], got_first[0], got_final[0], e0);
        end
        checks++;
        if (got_blk[1] !== e1 || got_first[1] !== 0 || got_final[1] !== 1) begin
            errors++;
            $display("FAIL len64_blk2: got %h f=%b l=%b want %h 0 1",
                     got_blk[1], got_first[1], got_final[1], e1);
        end
        checks++;
        if ((t_val - t_acc) / 10 + 1 != 1) begin
            errors++;
            $display("FAIL len64_latency: got %0d want 1", (t_val - t_acc) / 10 + 1);
        end
    endtask

    // Presents "abc" and waits for its block to be offered.
    task automatic offer_abc(output bit ok);
        int wt;
        @(negedge clk);
        word_i = 32'h6162_6300; bytes_i = 3'd3; last_i = 1; valid_i = 1;
        wt = 0;
        while (!ready_o && wt < 100) begin @(negedge clk); wt++; end
        @(negedge clk);
        valid_i = 0; last_i = 0;
        wt = 0;
        while (!blk_valid_o && wt < 100) begin @(negedge clk); wt++; end
        ok = blk_valid_o;
    endtask

    task automatic test_backpressure();
        blk_t held, e;
        bit   ok;
        e = wd(0, 32'h6162_6380) | wd(15, 32'h0000_0018);
        blk_accept_i = 0;
        offer_abc(ok);
        held = block_o;
        checks++;
        if (!ok || held !== e) begin
            errors++;
            $display("FAIL bp_offer: got v=%b %h want 1 %h", ok, held, e);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (block_o !== held || ready_o !== 0 || blk_valid_o !== 1) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d got v=%b rdy=%b stable=%b want 1 0 1",
                         c, blk_valid_o, ready_o, block_o === held);
            end
        end
        blk_accept_i = 1;
        @(negedge clk);
        blk_accept_i = 0;
        checks++;
        if (blk_valid_o !== 0 || ready_o !== 0) begin
            errors++;
            $display("FAIL bp_after1: got v=%b rdy=%b want 0 0", blk_valid_o, ready_o);
        end
        @(negedge clk);
        checks++;
        if (ready_o !== 1 || busy_o !== 0) begin
            errors++;
            $display("FAIL bp_after2: got rdy=%b busy=%b want 1 0", ready_o, busy_o);
        end
    endtask

    task automatic test_reset_mid();
        byte unsigned m[$];
        blk_t e;
        bit   ok;
        m = '{8'h61, 8'h62, 8'h63};
        e = wd(0, 32'h6162_6380) | wd(15, 32'h0000_0018);
        blk_accept_i = 0;
        offer_abc(ok);
        #2 rst_n = 0;
        #1;
        checks++;
        if (!ok || blk_valid_o !== 0 || busy_o !== 0 || block_o !== '0) begin
            errors++;
            $display("FAIL rstmid_drop: got offered=%b v=%b busy=%b want 1 0 0",
                     ok, blk_valid_o, busy_o);
        end
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        run_msg(m, 0, 100);
        checks++;
        if (tmo || got_blk.size() != 1 || got_blk[0] !== e ||
            got_first[0] !== 1 || got_final[0] !== 1) begin
            errors++;
            $display("FAIL rstmid_abc: got n=%0d %h want 1 %h", got_blk.size(),
                     got_blk.size() ? got_blk[0] : '0, e);
        end
    endtask

    task automatic test_random();
        int lens[8] = '{55, 56, 63, 64, 119, 120, 4, 60};
        byte unsigned m[$];
        int n;
        for (int t = 0; t < 28; t++) begin
            n = (t < 8) ? lens[t] : $urandom_range(0, 190);
            m.delete();
            for (int i = 0; i < n; i++) m.push_back(8'($urandom()));
            build_ref(m);
            run_msg(m, 1'($urandom_range(0, 1)), $urandom_range(30, 100));
            checks++;
            if (tmo || got_blk.size() != exp_blk.size()) begin
                errors++;
                $display("FAIL rand_count: len %0d got %0d tmo=%b want %0d",
                         n, got_blk.size(), tmo, exp_blk.size());
                continue;
            end
            for (int b = 0; b < exp_blk.size(); b++) begin
                checks++;
                if (got_blk[b] !== exp_blk[b] || got_first[b] !== (b == 0) ||
                    got_final[b] !== (b == exp_blk.size() - 1)) begin
                    errors++;
                    $display("FAIL rand_block: len %0d blk %0d got %h f=%b l=%b want %h",
                             n, b, got_blk[b], got_first[b], got_final[b], exp_blk[b]);
                end
            end
            checks++;
            if (busy_o !== 0) begin
                errors++;
                $display("FAIL rand_busy: len %0d got %b want 0", n, busy_o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_55();
        test_56();
        test_64();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
